// File: rtl/voice_pkg.sv
// Shared types for the voice allocator: per-voice state, control FSM states,
// default widths, and a helper that ranks voice states for steal selection.
// Imported by note_period_rom and voice_allocator.
package voice_pkg;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_HELD = 2'd1,
    V_REL  = 2'd2
  } vstate_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOOK  = 2'd1,
    S_ISSUE = 2'd2
  } ctrl_t;

  localparam int NOTE_W_DEF = 7;
  localparam int PER_W_DEF  = 32;

  // Steal preference class: releasing voices are cheaper to steal than held ones.
  function automatic logic [1:0] steal_class(input vstate_t s);
    case (s)
      V_REL:   return 2'd2;
      V_HELD:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Periods of MIDI notes 0..11 in 50 MHz clock cycles; higher octaves halve.
  // Note 9 (A, 13.75 Hz) shifted right by 5 gives A4 = 440 Hz = 113636 cycles.
  function automatic logic [23:0] base_period(input logic [3:0] semi);
    case (semi)
      4'd0:    return 24'd6115610;
      4'd1:    return 24'd5772368;
      4'd2:    return 24'd5448389;
      4'd3:    return 24'd5142595;
      4'd4:    return 24'd4853963;
      4'd5:    return 24'd4581531;
      4'd6:    return 24'd4324389;
      4'd7:    return 24'd4081680;
      4'd8:    return 24'd3852593;
      4'd9:    return 24'd3636364;
      4'd10:   return 24'd3432270;
      default: return 24'd3239632;
    endcase
  endfunction

endpackage

// File: rtl/note_period_rom.sv
// Note number -> oscillator period (clk_fast cycles per waveform period).
// Latency: 1 cycle, registered output. No backpressure; reads every cycle.
// Ports: clk, rst (sync, active-high), addr (note number), data_q (period).
module note_period_rom
  import voice_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int PER_W  = PER_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] addr,
  output logic [PER_W-1:0]  data_q
);

  logic [PER_W-1:0] data_d;
  int               n;
  logic [3:0]       semi;
  logic [3:0]       oct;

  // 128-entry table built as a 12-entry octave-0 table plus a per-octave shift.
  always_comb begin
    n      = int'(addr);
    semi   = 4'(n % 12);
    oct    = 4'(n / 12);
    data_d = PER_W'(base_period(semi) >> oct);
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

endmodule

// File: rtl/voice_allocator.sv
// Assigns note-on/off events to NV notebank voices, drives per-voice pulses and periods.
// Latency: event accepted at T, pulse/period/busy visible at T+2; 1 event per 3 cycles.
// Backpressure: ev_ready low during reset and for the two cycles after each accept.
// Ports: clk, rst (sync, active-high); ev_valid/ev_ready/ev_on/ev_note event input;
//   voice_done per-voice release-complete; note_on/note_off pulses; period_flat
//   (voice i at [i*PER_W +: PER_W]); voice_busy; drop_cnt (saturating dropped note-ons).
// Build option: define VOICE_STEAL_EN to steal the oldest voice when all are busy
//   instead of dropping the note-on.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NV     = 4,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int PER_W  = PER_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic                ev_on,
  input  logic [NOTE_W-1:0]   ev_note,
  input  logic [NV-1:0]       voice_done,
  output logic [NV-1:0]       note_on,
  output logic [NV-1:0]       note_off,
  output logic [NV*PER_W-1:0] period_flat,
  output logic [NV-1:0]       voice_busy,
  output logic [7:0]          drop_cnt
);

  localparam int AW = $clog2(NV);

  ctrl_t             ctrl_q, ctrl_d;
  logic              ev_on_q, ev_on_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  vstate_t           vstate_q [NV];
  vstate_t           vstate_d [NV];
  logic [NOTE_W-1:0] vnote_q [NV];
  logic [NOTE_W-1:0] vnote_d [NV];
  logic [AW-1:0]     age_q [NV];
  logic [AW-1:0]     age_d [NV];
  logic [PER_W-1:0]  per_q [NV];
  logic [PER_W-1:0]  per_d [NV];
  logic [NV-1:0]     note_on_q, note_on_d;
  logic [NV-1:0]     note_off_q, note_off_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              accept;
  logic [NOTE_W-1:0] rom_addr;
  logic [PER_W-1:0]  rom_dat;

  logic              hit_fnd, idle_fnd, off_fnd;
  logic [AW-1:0]     hit_idx, idle_idx, off_idx;
  logic              tgt_vld;
  logic [AW-1:0]     tgt_idx;
  int                old_age;

  assign ev_ready = (ctrl_q == S_IDLE) && !rst;
  assign accept   = ev_valid && ev_ready;

  // Address the ROM with the live note while idle so its data is ready in S_LOOK,
  // then hold the latched note so the output stays stable.
  assign rom_addr = (ctrl_q == S_IDLE) ? ev_note : ev_note_q;

  note_period_rom #(
    .NOTE_W (NOTE_W),
    .PER_W  (PER_W)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .addr   (rom_addr),
    .data_q (rom_dat)
  );

  // Candidate searches; descending loop so the lowest index is the final winner.
  always_comb begin
    hit_fnd  = 1'b0;
    idle_fnd = 1'b0;
    off_fnd  = 1'b0;
    hit_idx  = '0;
    idle_idx = '0;
    off_idx  = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (vstate_q[i] != V_IDLE && vnote_q[i] == ev_note_q) begin
        hit_fnd = 1'b1;
        hit_idx = AW'(i);
      end
      if (vstate_q[i] == V_IDLE) begin
        idle_fnd = 1'b1;
        idle_idx = AW'(i);
      end
      if (vstate_q[i] == V_HELD && vnote_q[i] == ev_note_q) begin
        off_fnd = 1'b1;
        off_idx = AW'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [AW-1:0] steal_idx;
  logic [1:0]    best_cls;
  logic [AW-1:0] best_age;

  // Best class first (REL over HELD), then highest age; ties go to the lowest index.
  always_comb begin
    steal_idx = '0;
    best_cls  = '0;
    best_age  = '0;
    for (int i = 0; i < NV; i++) begin
      if (steal_class(vstate_q[i]) > best_cls ||
          (steal_class(vstate_q[i]) == best_cls && age_q[i] > best_age)) begin
        best_cls  = steal_class(vstate_q[i]);
        best_age  = age_q[i];
        steal_idx = AW'(i);
      end
    end
  end
`endif

  always_comb begin
    ctrl_d     = ctrl_q;
    ev_on_d    = ev_on_q;
    ev_note_d  = ev_note_q;
    note_on_d  = '0;
    note_off_d = '0;
    drop_cnt_d = drop_cnt_q;
    tgt_vld    = 1'b0;
    tgt_idx    = '0;
    old_age    = 0;
    for (int i = 0; i < NV; i++) begin
      vstate_d[i] = vstate_q[i];
      vnote_d[i]  = vnote_q[i];
      age_d[i]    = age_q[i];
      per_d[i]    = per_q[i];
      if (vstate_q[i] == V_REL && voice_done[i]) vstate_d[i] = V_IDLE;
    end

    case (ctrl_q)
      S_IDLE: begin
        if (accept) begin
          ev_on_d   = ev_on;
          ev_note_d = ev_note;
          ctrl_d    = S_LOOK;
        end
      end
      S_LOOK: begin
        ctrl_d = S_ISSUE;
        if (ev_on_q) begin
          if (hit_fnd) begin
            tgt_vld = 1'b1;
            tgt_idx = hit_idx;
          end else if (idle_fnd) begin
            tgt_vld = 1'b1;
            tgt_idx = idle_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            tgt_vld = 1'b1;
            tgt_idx = steal_idx;
`else
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`endif
          end
        end else if (off_fnd) begin
          note_off_d[off_idx] = 1'b1;
          vstate_d[off_idx]   = V_REL;
        end
      end
      S_ISSUE: ctrl_d = S_IDLE;
      default: ctrl_d = S_IDLE;
    endcase

    // Issue is applied after the done-reclaim so it wins on the same voice.
    if (tgt_vld) begin
      // An idle voice has no meaningful rank: treat it as older than every busy
      // voice so all busy voices age by one (saturating at NV-1).
      old_age = (vstate_q[tgt_idx] == V_IDLE) ? NV : int'(age_q[tgt_idx]);
      for (int j = 0; j < NV; j++) begin
        if (AW'(j) != tgt_idx && vstate_q[j] != V_IDLE &&
            int'(age_q[j]) < old_age && age_q[j] != AW'(NV - 1)) begin
          age_d[j] = age_q[j] + AW'(1);
        end
      end
      note_on_d[tgt_idx] = 1'b1;
      vstate_d[tgt_idx]  = V_HELD;
      vnote_d[tgt_idx]   = ev_note_q;
      per_d[tgt_idx]     = rom_dat;
      age_d[tgt_idx]     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= S_IDLE;
      ev_on_q    <= 1'b0;
      ev_note_q  <= '0;
      note_on_q  <= '0;
      note_off_q <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < NV; i++) begin
        vstate_q[i] <= V_IDLE;
        vnote_q[i]  <= '0;
        age_q[i]    <= '0;
        per_q[i]    <= '0;
      end
    end else begin
      ctrl_q     <= ctrl_d;
      ev_on_q    <= ev_on_d;
      ev_note_q  <= ev_note_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < NV; i++) begin
        vstate_q[i] <= vstate_d[i];
        vnote_q[i]  <= vnote_d[i];
        age_q[i]    <= age_d[i];
        per_q[i]    <= per_d[i];
      end
    end
  end

  assign note_on  = note_on_q;
  assign note_off = note_off_q;
  assign drop_cnt = drop_cnt_q;

  for (genvar g = 0; g < NV; g++) begin : g_out
    assign period_flat[g*PER_W +: PER_W] = per_q[g];
    assign voice_busy[g]                 = (vstate_q[g] != V_IDLE);
  end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int NV     = 4;
  localparam int NOTE_W = 7;
  localparam int PER_W  = 32;

  localparam int OP_ON   = 0;
  localparam int OP_OFF  = 1;
  localparam int OP_DONE = 2;

  // Outcome of a note-on when all four voices are busy.
`ifdef VOICE_STEAL_EN
  localparam logic [3:0] FULL_ON   = 4'b0010;
  localparam int         FULL_VIDX = 1;
  localparam logic [7:0] FULL_DROP = 8'd0;
`else
  localparam logic [3:0] FULL_ON   = 4'b0000;
  localparam int         FULL_VIDX = -1;
  localparam logic [7:0] FULL_DROP = 8'd1;
`endif

  typedef struct {
    int         op;
    logic [6:0] note;
    logic [3:0] done;
    logic [3:0] e_on;
    logic [3:0] e_off;
    logic [3:0] e_busy;
    int         e_vidx;
    logic [31:0] e_per;
    logic [7:0] e_drop;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ev_valid = 1'b0;
  logic              ev_on = 1'b0;
  logic [NOTE_W-1:0] ev_note = '0;
  logic [NV-1:0]     voice_done = '0;
  logic              ev_ready;
  logic [NV-1:0]     note_on;
  logic [NV-1:0]     note_off;
  logic [NV*PER_W-1:0] period_flat;
  logic [NV-1:0]     voice_busy;
  logic [7:0]        drop_cnt;

  int checks = 0;
  int errors = 0;

  vec_t vecs [17];

  voice_allocator #(
    .NV     (NV),
    .NOTE_W (NOTE_W),
    .PER_W  (PER_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_on       (ev_on),
    .ev_note     (ev_note),
    .voice_done  (voice_done),
    .note_on     (note_on),
    .note_off    (note_off),
    .period_flat (period_flat),
    .voice_busy  (voice_busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    if (v.op == OP_DONE) begin
      @(negedge clk);
      voice_done = v.done;
      @(negedge clk);
      voice_done = '0;
      chk($sformatf("v%0d busy", k), 128'(voice_busy), 128'(v.e_busy));
      chk($sformatf("v%0d note_on", k), 128'(note_on), 128'(v.e_on));
      chk($sformatf("v%0d note_off", k), 128'(note_off), 128'(v.e_off));
    end else begin
      @(negedge clk);
      chk($sformatf("v%0d ready_idle", k), 128'(ev_ready), 128'(1'b1));
      ev_valid = 1'b1;
      ev_on    = (v.op == OP_ON);
      ev_note  = v.note;
      @(posedge clk);
      #1;
      ev_valid   = 1'b0;
      voice_done = v.done;
      chk($sformatf("v%0d ready_t1", k), 128'(ev_ready), 128'(1'b0));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d note_on", k), 128'(note_on), 128'(v.e_on));
      chk($sformatf("v%0d note_off", k), 128'(note_off), 128'(v.e_off));
      chk($sformatf("v%0d ready_t2", k), 128'(ev_ready), 128'(1'b0));
      @(posedge clk);
      #1;
      voice_done = '0;
      chk($sformatf("v%0d on_cleared", k), 128'(note_on), 128'(0));
      chk($sformatf("v%0d off_cleared", k), 128'(note_off), 128'(0));
      chk($sformatf("v%0d ready_t3", k), 128'(ev_ready), 128'(1'b1));
    end
    chk($sformatf("v%0d busy_after", k), 128'(voice_busy), 128'(v.e_busy));
    chk($sformatf("v%0d drop_cnt", k), 128'(drop_cnt), 128'(v.e_drop));
    if (v.e_vidx >= 0)
      chk($sformatf("v%0d period[%0d]", k, v.e_vidx),
          128'(period_flat[v.e_vidx*PER_W +: PER_W]), 128'(v.e_per));
  endtask

  initial begin
    //          op       note   done     on       off      busy     vidx       period       drop
    vecs[0]  = '{OP_ON,   7'd69, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0,         32'd113636, 8'd0};
    vecs[1]  = '{OP_ON,   7'd60, 4'b0000, 4'b0010, 4'b0000, 4'b0011, 1,         32'd191112, 8'd0};
    vecs[2]  = '{OP_ON,   7'd62, 4'b0000, 4'b0100, 4'b0000, 4'b0111, 2,         32'd170262, 8'd0};
    vecs[3]  = '{OP_ON,   7'd64, 4'b0000, 4'b1000, 4'b0000, 4'b1111, 3,         32'd151686, 8'd0};
    vecs[4]  = '{OP_OFF,  7'd62, 4'b0000, 4'b0000, 4'b0100, 4'b1111, -1,        32'd0,      8'd0};
    vecs[5]  = '{OP_DONE, 7'd0,  4'b0100, 4'b0000, 4'b0000, 4'b1011, 2,         32'd170262, 8'd0};
    vecs[6]  = '{OP_ON,   7'd65, 4'b0000, 4'b0100, 4'b0000, 4'b1111, 2,         32'd143172, 8'd0};
    vecs[7]  = '{OP_ON,   7'd69, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 0,         32'd113636, 8'd0};
    vecs[8]  = '{OP_OFF,  7'd50, 4'b0000, 4'b0000, 4'b0000, 4'b1111, -1,        32'd0,      8'd0};
    vecs[9]  = '{OP_ON,   7'd70, 4'b0000, FULL_ON, 4'b0000, 4'b1111, FULL_VIDX, 32'd107258, FULL_DROP};
    vecs[10] = '{OP_OFF,  7'd64, 4'b0000, 4'b0000, 4'b1000, 4'b1111, -1,        32'd0,      FULL_DROP};
    vecs[11] = '{OP_ON,   7'd64, 4'b1000, 4'b1000, 4'b0000, 4'b1111, 3,         32'd151686, FULL_DROP};
    vecs[12] = '{OP_DONE, 7'd0,  4'b1000, 4'b0000, 4'b0000, 4'b1111, 3,         32'd151686, FULL_DROP};
    vecs[13] = '{OP_OFF,  7'd64, 4'b0000, 4'b0000, 4'b1000, 4'b1111, -1,        32'd0,      FULL_DROP};
    vecs[14] = '{OP_DONE, 7'd0,  4'b1000, 4'b0000, 4'b0000, 4'b0111, 3,         32'd151686, FULL_DROP};
    vecs[15] = '{OP_DONE, 7'd0,  4'b0001, 4'b0000, 4'b0000, 4'b0111, 0,         32'd113636, FULL_DROP};
    vecs[16] = '{OP_ON,   7'd72, 4'b0000, 4'b1000, 4'b0000, 4'b1111, 3,         32'd95556,  FULL_DROP};

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ev_ready", 128'(ev_ready), 128'(0));
    chk("rst note_on", 128'(note_on), 128'(0));
    chk("rst note_off", 128'(note_off), 128'(0));
    chk("rst period_flat", 128'(period_flat), 128'(0));
    chk("rst voice_busy", 128'(voice_busy), 128'(0));
    chk("rst drop_cnt", 128'(drop_cnt), 128'(0));
    rst = 1'b0;
    #1;
    chk("post-rst ev_ready", 128'(ev_ready), 128'(1));

    for (int k = 0; k < 17; k++) run_vec(k, vecs[k]);

    // Reset while the event sits in S_LOOK: nothing may be issued.
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_note  = 7'd71;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst note_on", 128'(note_on), 128'(0));
    chk("midrst note_off", 128'(note_off), 128'(0));
    chk("midrst period_flat", 128'(period_flat), 128'(0));
    chk("midrst voice_busy", 128'(voice_busy), 128'(0));
    chk("midrst drop_cnt", 128'(drop_cnt), 128'(0));
    chk("midrst ev_ready", 128'(ev_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst ready_after", 128'(ev_ready), 128'(1));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst no_stale_pulse c%0d", c), 128'(note_on), 128'(0));
    end

    // Allocation restarts at voice 0 after reset.
    run_vec(17, '{OP_ON, 7'd69, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 32'd113636, 8'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
